// File: rtl/mux16_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared constants and FSM state encoding for mux16_rr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N  = 16;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mux16_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter_if
//  Brief    : Request/grant/select bundle between requesters and the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mux16_rr_arbiter_if;
  import arb_pkg::*;

  logic [N-1:0]  req;
  logic          done;
  logic [SW-1:0] sel;
  logic [N-1:0]  gnt;
  logic          active;
  logic          timeout;

  modport slave (
    input  req, done,
    output sel, gnt, active, timeout
  );

  modport master (
    output req, done,
    input  sel, gnt, active, timeout
  );
endinterface
`default_nettype wire

// File: rtl/mux16_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick16
//  Brief    : Wrapped priority finder: first set req bit at or above ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick16
  import arb_pkg::*;
(
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_off;

  // Rotating so ptr lands at bit 0 turns the wrapped search into a plain LSB-first scan
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: N];

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SW'(i);
      end
    end
  end

  assign idx   = ptr + w_off;
  assign found = |req;

endmodule
`default_nettype wire

// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter
//  Brief    : Round-robin arbiter driving the 16:1 mux select with hold timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAXHOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux16_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] c_HOLD_LAST = 8'(MAXHOLD - 1);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic          r_active, w_active_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic [SW-1:0] w_pick_ptr;
  logic [SW-1:0] w_idx;
  logic          w_found;

  // During RELEASE the search already starts past the source just served
  assign w_pick_ptr = (r_state == RELEASE) ? r_sel + SW'(1) : r_ptr;

  rr_pick16 u_pick (
    .req   (bus.req),
    .ptr   (w_pick_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_active_nxt  = r_active;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_sel_nxt    = w_idx;
          w_gnt_nxt    = N'(1) << w_idx;
          w_active_nxt = 1'b1;
          w_hold_nxt   = '0;
        end
      end
      GRANT: begin
        w_hold_nxt = r_hold + 8'd1;
        if (bus.done || !bus.req[r_sel]) begin
          w_state_nxt  = RELEASE;
          w_gnt_nxt    = '0;
          w_active_nxt = 1'b0;
        end else if (r_hold == c_HOLD_LAST) begin
          w_state_nxt   = RELEASE;
          w_gnt_nxt     = '0;
          w_active_nxt  = 1'b0;
          w_timeout_nxt = 1'b1;
        end
      end
      RELEASE: begin
        w_ptr_nxt = w_pick_ptr;
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_sel_nxt    = w_idx;
          w_gnt_nxt    = N'(1) << w_idx;
          w_active_nxt = 1'b1;
          w_hold_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_gnt     <= '0;
      r_active  <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_active  <= w_active_nxt;
      r_timeout <= w_timeout_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.gnt     = r_gnt;
  assign bus.active  = r_active;
  assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux16_rr_arbiter
//  Brief    : Directed and randomized check of mux16_rr_arbiter against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_arbiter;

  localparam int MAXHOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  mux16_rr_arbiter_if bus ();

  mux16_rr_arbiter #(.MAXHOLD(MAXHOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: who owns the grant (-1 = nobody), how long, and whether this is the gap cycle
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_age   = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;

  function automatic int winner(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  initial begin : model
    int w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_sel = 0; m_age = 0; m_gap = 1'b0; m_to = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_owner >= 0) begin
          m_age = m_age + 1;
          if (bus.done || !bus.req[m_owner]) begin
            m_owner = -1; m_gap = 1'b1;
          end else if (m_age == MAXHOLD) begin
            m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
          end
        end else begin
          if (m_gap) begin
            m_gap = 1'b0;
            m_ptr = (m_sel + 1) % 16;
          end
          w = winner(bus.req, m_ptr);
          if (w >= 0) begin
            m_owner = w; m_sel = w; m_age = 0;
          end
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic expect_out(string nm, int s, logic [15:0] g, logic a, logic t);
    check({nm, " sel"},     32'(bus.sel),     32'(s));
    check({nm, " gnt"},     32'(bus.gnt),     32'(g));
    check({nm, " active"},  32'(bus.active),  32'(a));
    check({nm, " timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  initial begin : compare
    logic [15:0] eg;
    forever begin
      @(negedge clk);
      eg = 16'h0001;
      eg = (m_owner >= 0) ? (eg << m_owner) : 16'h0000;
      check("model gnt",     32'(bus.gnt),     32'(eg));
      check("model sel",     32'(bus.sel),     32'(m_sel));
      check("model active",  32'(bus.active),  32'(m_owner >= 0));
      check("model timeout", 32'(bus.timeout), 32'(m_to));
      check("onehot0 gnt",   32'($onehot0(bus.gnt)), 32'(1));
      check("gnt vs active", 32'(bus.gnt != 16'h0), 32'(bus.active));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s;
    logic [15:0] g;
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    cyc();
    cyc();
    expect_out("reset", 0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single requester, done during the third grant cycle
    bus.req = 16'h0100;
    cyc(); expect_out("single g1", 8, 16'h0100, 1'b1, 1'b0);
    cyc(); expect_out("single g2", 8, 16'h0100, 1'b1, 1'b0);
    cyc(); expect_out("single g3", 8, 16'h0100, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc(); expect_out("single rel", 8, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("single regrant", 8, 16'h0100, 1'b1, 1'b0);
    bus.req = 16'h0000;
    cyc(); expect_out("single drop", 8, 16'h0000, 1'b0, 1'b0);
    cyc(); expect_out("single idle", 8, 16'h0000, 1'b0, 1'b0);

    // Fairness between sources 0 and 15
    do_reset();
    bus.req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 1) ? 15 : 0;
      g = 16'h0001;
      g = g << s;
      cyc(); expect_out("rr g1", s, g, 1'b1, 1'b0);
      cyc(); expect_out("rr g2", s, g, 1'b1, 1'b0);
      bus.done = 1'b1;
      cyc(); expect_out("rr gap", s, 16'h0000, 1'b0, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 16'h0000;
    cyc(); cyc(); cyc();

    // Pointer wrap after serving 14
    do_reset();
    bus.req = 16'h4000;
    cyc(); expect_out("wrap 14", 14, 16'h4000, 1'b1, 1'b0);
    bus.req = 16'h4003; bus.done = 1'b1;
    cyc(); expect_out("wrap rel14", 14, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("wrap 0", 0, 16'h0001, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc(); expect_out("wrap rel0", 0, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("wrap 1", 1, 16'h0002, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc(); expect_out("wrap rel1", 1, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("wrap 14b", 14, 16'h4000, 1'b1, 1'b0);
    bus.req = 16'h0000;
    cyc(); cyc();

    // Hold timeout, then pointer must have advanced to 6
    do_reset();
    bus.req = 16'h0020;
    for (int k = 0; k < MAXHOLD; k++) begin
      cyc(); expect_out("to hold", 5, 16'h0020, 1'b1, 1'b0);
    end
    cyc(); expect_out("to pulse", 5, 16'h0000, 1'b0, 1'b1);
    bus.req = 16'h0061;
    cyc(); expect_out("to ptr6", 6, 16'h0040, 1'b1, 1'b0);
    bus.req = 16'h0000;
    cyc(); cyc();

    // done coinciding with hold expiry, then done together with req drop
    do_reset();
    bus.req = 16'h0004;
    for (int k = 0; k < MAXHOLD; k++) begin
      cyc(); expect_out("coll hold", 2, 16'h0004, 1'b1, 1'b0);
    end
    bus.done = 1'b1;
    cyc(); expect_out("coll rel", 2, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("coll regrant", 2, 16'h0004, 1'b1, 1'b0);
    bus.req = 16'h0000; bus.done = 1'b1;
    cyc(); expect_out("coll drop rel", 2, 16'h0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc(); expect_out("coll idle", 2, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant
    bus.req = 16'h0010;
    cyc(); expect_out("pre rst", 4, 16'h0010, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 expect_out("async rst", 0, 16'h0000, 1'b0, 1'b0);
    bus.req = 16'h0001;
    cyc();
    rst_n = 1'b1;
    cyc(); expect_out("post rst", 0, 16'h0001, 1'b1, 1'b0);
    bus.req = 16'h0000;
    cyc(); cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        #1 expect_out("rand rst", 0, 16'h0000, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
      end
      bus.done = (m_owner >= 0) && ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       bus.req = 16'($urandom);
        1:       bus.req = 16'h0000;
        2, 3:    bus.req ^= 16'(1) << $urandom_range(0, 15);
        default: ;
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
